irq_arbiter: RTL

Platform interrupt arbiter that merges `N_SRC` level-sensitive peripheral interrupt lines into the single `externalIRQ` input of the core-local interrupt controller. Per-source synchronising gateways, enable mask, priority and threshold registers, and a claim/complete handshake let the trap handler identify and retire one source at a time. Sits between the peripherals and the core; the core accesses it through the same `A/WE/WD/RD` register-port style used by the interrupt controller.

---
 rtl/irq_arbiter_pkg.sv | 18 +
 rtl/irq_gateway.sv | 45 ++++
 rtl/irq_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the platform interrupt arbiter: register addresses,
// the "no interrupt" ID and the claim-ID width helper.
package irq_arbiter_pkg;

  localparam logic [4:0] IRQ_A_PENDING   = 5'd0;
  localparam logic [4:0] IRQ_A_ENABLE    = 5'd1;
  localparam logic [4:0] IRQ_A_THRESHOLD = 5'd2;
  localparam logic [4:0] IRQ_A_CLAIM     = 5'd3;
  localparam logic [4:0] IRQ_A_PRIO_BASE = 5'd8;

  localparam int unsigned IRQ_ID_NONE = 0;

  // IDs run 1..n_src with 0 reserved for "none".
  function automatic int unsigned irq_id_width(int unsigned n_src);
    return $clog2(n_src + 1);
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: 2-flop synchroniser plus pending and
// in-service flags driven by the arbiter's claim/complete pulses.
module irq_gateway (
  input  logic CLK,
  input  logic reset,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic sync1_q, sync2_q;
  logic pending_q, pending_d;
  logic in_service_q, in_service_d;

  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (claim_i) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else begin
      if (complete_i) in_service_d = 1'b0;
      // Re-pend only once the previous request has been fully retired.
      if (sync2_q && !pending_q && !in_service_q) pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      sync1_q      <= src_i;
      sync2_q      <= sync1_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter top: register file, winner selection and read mux.
// Define IRQ_ARBITER_PRIO_EN for per-source priority registers; otherwise all sources have priority 1.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [N_SRC-1:0]  src,
  input  logic [4:0]        A,
  input  logic              WE,
  input  logic              RE,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              externalIRQ
);

  localparam int unsigned ID_W = irq_id_width(N_SRC);

  logic [N_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio;
  logic [PRIO_W-1:0] prio_eff [N_SRC];
  logic [N_SRC-1:0]  pending, claim_vec, complete_vec, cand;
  logic              claim_en, complete_en;
  logic              unused_wd;

  assign claim_en    = RE && (A == IRQ_A_CLAIM);
  assign complete_en = WE && (A == IRQ_A_CLAIM);
  assign unused_wd   = ^WD;

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_vec[i]    = claim_en && (best_id_q == ID_W'(i + 1));
      complete_vec[i] = complete_en && (WD[4:0] == 5'(i + 1));
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .CLK        (CLK),
      .reset      (reset),
      .src_i      (src[g]),
      .claim_i    (claim_vec[g]),
      .complete_i (complete_vec[g]),
      .pending_o  (pending[g])
    );
  end

  always_comb begin
    enable_d    = enable_q;
    threshold_d = threshold_q;
    if (WE && (A == IRQ_A_ENABLE))    enable_d    = WD[N_SRC-1:0];
    if (WE && (A == IRQ_A_THRESHOLD)) threshold_d = WD[PRIO_W-1:0];
  end

`ifdef IRQ_ARBITER_PRIO_EN
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];

  always_comb begin
    prio_d = prio_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (WE && (int'(A) == int'(IRQ_A_PRIO_BASE) + i)) prio_d[i] = WD[PRIO_W-1:0];
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_eff = prio_d;
`else
  always_comb begin
    for (int i = 0; i < N_SRC; i++) prio_eff[i] = PRIO_W'(1);
  end
`endif

  // Winner is taken from the post-edge view: fresh register values and the
  // claimed source already removed, so back-to-back claims never repeat.
  always_comb begin
    best_id_d = ID_W'(IRQ_ID_NONE);
    best_prio = '0;
    cand      = pending & ~claim_vec & enable_d;
    for (int i = 0; i < N_SRC; i++) begin
      if (cand[i] && (prio_eff[i] > threshold_d) && (prio_eff[i] > best_prio)) begin
        best_prio = prio_eff[i];
        best_id_d = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      enable_q    <= '0;
      threshold_q <= '0;
      best_id_q   <= '0;
    end else begin
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      best_id_q   <= best_id_d;
    end
  end

  assign externalIRQ = (best_id_q != ID_W'(IRQ_ID_NONE));

  always_comb begin
    RD = '0;
    case (A)
      IRQ_A_PENDING:   RD[N_SRC-1:0]  = pending;
      IRQ_A_ENABLE:    RD[N_SRC-1:0]  = enable_q;
      IRQ_A_THRESHOLD: RD[PRIO_W-1:0] = threshold_q;
      IRQ_A_CLAIM:     RD[ID_W-1:0]   = best_id_q;
      default: begin
`ifdef IRQ_ARBITER_PRIO_EN
        for (int i = 0; i < N_SRC; i++) begin
          if (int'(A) == int'(IRQ_A_PRIO_BASE) + i) RD[PRIO_W-1:0] = prio_q[i];
        end
`endif
      end
    endcase
  end

endmodule
